// File: rtl/oisc_pkg.sv
// Shared definitions for the move-only core: move-map addresses, FSM states
// and the literal sign-extension helper.
package oisc_pkg;

    localparam int OISC_ZERO     = 'h0000;
    localparam int OISC_PC       = 'h0001;
    localparam int OISC_IMM      = 'h0002;
    localparam int OISC_MAR      = 'h0003;
    localparam int OISC_MEM      = 'h0004;
    localparam int OISC_COND     = 'h0005;
    localparam int OISC_HALT     = 'h0007;
    localparam int OISC_OPA      = 'h0008;
    localparam int OISC_ADD      = 'h0009;
    localparam int OISC_SUB      = 'h000A;
    localparam int OISC_RES      = 'h000B;
    localparam int OISC_GPR_BASE = 'h0020;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        MEMRD,
        MEMWR
    } oiscState;

    // Sign-extends the low 'width' bits of value to 64 bits; callers truncate.
    function automatic logic [63:0] signExtend(input logic [63:0] value, input int width);
        logic signed [63:0] shifted;
        shifted = $signed(value << (64 - width));
        return shifted >>> (64 - width);
    endfunction

endpackage

// File: rtl/oisc_regfile.sv
// General-purpose register file: one combinational read port, one synchronous
// write port, entry 0 always reads as zero.
module oisc_regfile #(
    parameter int DW   = 32,
    parameter int NGPR = 32,
    parameter int GW   = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [GW-1:0] readAddr,
    output logic [DW-1:0] readData,
    input  logic          writeEnable,
    input  logic [GW-1:0] writeAddr,
    input  logic [DW-1:0] writeData
);

    logic [DW-1:0] regs [NGPR];

    assign readData = (readAddr == '0) ? '0 : regs[readAddr];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NGPR; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEnable && (writeAddr != '0)) begin
            regs[writeAddr] <= writeData;
        end
    end

endmodule

// File: rtl/oisc_move_core.sv
// Second-generation move-only core: each instruction moves one source to one
// destination, with side effects (jump, skip, halt, ALU, SDRAM) keyed on address.
module oisc_move_core
    import oisc_pkg::*;
#(
    parameter int DW   = 32,
    parameter int MW   = 16,
    parameter int NGPR = 32,
    parameter int AW   = 16,
    parameter int PCW  = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Start,
    input  logic            Reset,
    output logic            Busy,
    output logic [PCW-1:0]  InstructionAddr,
    output logic            InstructionReadReady,
    input  logic            InstructionReadValid,
    input  logic [2*MW-1:0] InstructionReadData,
    output logic            SDRAMReadReady,
    input  logic            SDRAMReadValid,
    input  logic [DW-1:0]   SDRAMReadData,
    output logic [AW-1:0]   SDRAMReadAddr,
    input  logic            SDRAMWriteReady,
    output logic            SDRAMWriteValid,
    output logic [DW-1:0]   SDRAMWriteData,
    output logic [AW-1:0]   SDRAMWriteAddr
);

    localparam int GW = (NGPR > 1) ? $clog2(NGPR) : 1;

    oiscState       state, nextState;
    logic [PCW-1:0] pc;
    logic [DW-1:0]  imm, opa, res, wrData;
    logic [AW-1:0]  mar;
    logic [MW-1:0]  srcReg, dstReg;
    logic [DW-1:0]  srcValue, moveValue, gprReadData;
    logic           fetchAccept, commit, wrLoad, pcAdvance;

    function automatic logic isGpr(input logic [MW-1:0] a);
        return (int'(a) >= OISC_GPR_BASE) && (int'(a) < OISC_GPR_BASE + NGPR);
    endfunction

    function automatic logic [GW-1:0] gprIndex(input logic [MW-1:0] a);
        logic [MW-1:0] offset;
        offset = a - MW'(OISC_GPR_BASE);
        return offset[GW-1:0];
    endfunction

    oisc_regfile #(.DW(DW), .NGPR(NGPR), .GW(GW)) regfile (
        .CLK        (CLK),
        .RST        (RST),
        .readAddr   (gprIndex(srcReg)),
        .readData   (gprReadData),
        .writeEnable(commit && isGpr(dstReg)),
        .writeAddr  (gprIndex(dstReg)),
        .writeData  (moveValue)
    );

    // MEM as a source is not handled here; it comes from SDRAM in MEMRD.
    always_comb begin
        srcValue = '0;
        if (isGpr(srcReg)) begin
            srcValue = gprReadData;
        end else begin
            case (srcReg)
                MW'(OISC_PC):  srcValue = DW'(pc);
                MW'(OISC_IMM): srcValue = imm;
                MW'(OISC_MAR): srcValue = DW'(mar);
                MW'(OISC_OPA): srcValue = opa;
                MW'(OISC_RES): srcValue = res;
                default:       srcValue = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState   = state;
        fetchAccept = 1'b0;
        commit      = 1'b0;
        wrLoad      = 1'b0;
        pcAdvance   = 1'b0;
        moveValue   = (state == MEMRD) ? SDRAMReadData : srcValue;
        case (state)
            IDLE: begin
                if (Start) nextState = FETCH;
            end
            FETCH: begin
                if (InstructionReadValid) begin
                    fetchAccept = 1'b1;
                    nextState   = EXEC;
                end
            end
            EXEC: begin
                if (srcReg == MW'(OISC_MEM)) begin
                    nextState = MEMRD;
                end else if (dstReg == MW'(OISC_MEM)) begin
                    wrLoad    = 1'b1;
                    nextState = MEMWR;
                end else begin
                    commit    = 1'b1;
                    nextState = (dstReg == MW'(OISC_HALT)) ? IDLE : FETCH;
                end
            end
            MEMRD: begin
                if (SDRAMReadValid) begin
                    if (dstReg == MW'(OISC_MEM)) begin
                        wrLoad    = 1'b1;
                        nextState = MEMWR;
                    end else begin
                        commit    = 1'b1;
                        nextState = (dstReg == MW'(OISC_HALT)) ? IDLE : FETCH;
                    end
                end
            end
            MEMWR: begin
                if (SDRAMWriteReady) begin
                    pcAdvance = 1'b1;
                    nextState = FETCH;
                end
            end
            default: nextState = IDLE;
        endcase
        // Soft reset aborts whatever is in flight, including a pending handshake.
        if (Reset) begin
            nextState   = IDLE;
            fetchAccept = 1'b0;
            commit      = 1'b0;
            wrLoad      = 1'b0;
            pcAdvance   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc     <= '0;
            imm    <= '0;
            mar    <= '0;
            opa    <= '0;
            res    <= '0;
            wrData <= '0;
            srcReg <= '0;
            dstReg <= '0;
        end else begin
            if (fetchAccept) begin
                srcReg <= InstructionReadData[2*MW-1:MW];
                dstReg <= InstructionReadData[MW-1:0];
            end
            if (wrLoad) wrData <= moveValue;
            if (commit) begin
                case (dstReg)
                    MW'(OISC_IMM): imm <= DW'(signExtend(64'(srcReg), MW));
                    MW'(OISC_MAR): mar <= AW'(moveValue);
                    MW'(OISC_OPA): opa <= moveValue;
                    MW'(OISC_ADD): res <= opa + moveValue;
                    MW'(OISC_SUB): res <= opa - moveValue;
                    default: ;
                endcase
            end
            if (Reset) begin
                pc <= '0;
            end else if (commit) begin
                if (dstReg == MW'(OISC_PC)) begin
                    pc <= PCW'(moveValue);
                end else if ((dstReg == MW'(OISC_COND)) && (moveValue == '0)) begin
                    pc <= pc + PCW'(2);
                end else begin
                    pc <= pc + PCW'(1);
                end
            end else if (pcAdvance) begin
                pc <= pc + PCW'(1);
            end
        end
    end

    assign Busy                 = (state != IDLE);
    assign InstructionAddr      = pc;
    assign InstructionReadReady = (state == FETCH) && !Reset;
    assign SDRAMReadReady       = (state == MEMRD);
    assign SDRAMReadAddr        = mar;
    assign SDRAMWriteValid      = (state == MEMWR);
    assign SDRAMWriteData       = wrData;
    assign SDRAMWriteAddr       = mar;

endmodule

// File: tb/tb_oisc_move_core.sv
// Directed bench for oisc_move_core: a program table of moves with hand-computed
// fetch addresses, stall counts and SDRAM traffic, then reset and wrap sequences.
module tb_oisc_move_core;

    localparam logic [15:0] A_ZERO = 16'h0000;
    localparam logic [15:0] A_PC   = 16'h0001;
    localparam logic [15:0] A_IMM  = 16'h0002;
    localparam logic [15:0] A_MAR  = 16'h0003;
    localparam logic [15:0] A_MEM  = 16'h0004;
    localparam logic [15:0] A_COND = 16'h0005;
    localparam logic [15:0] A_UNM  = 16'h0006;
    localparam logic [15:0] A_HALT = 16'h0007;
    localparam logic [15:0] A_OPA  = 16'h0008;
    localparam logic [15:0] A_ADD  = 16'h0009;
    localparam logic [15:0] A_SUB  = 16'h000A;
    localparam logic [15:0] A_RES  = 16'h000B;
    localparam logic [15:0] A_G0   = 16'h0020;
    localparam logic [15:0] A_G1   = 16'h0021;
    localparam logic [15:0] A_G2   = 16'h0022;
    localparam logic [15:0] A_G3   = 16'h0023;
    localparam logic [15:0] MAR_EXP = 16'h0010;

    localparam int K_NONE = 0;
    localparam int K_WR   = 1;
    localparam int K_RD   = 2;
    localparam int K_RDWR = 3;

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] addr;
        int          waitCycles;
        int          kind;
        logic [31:0] rdData;
        int          delay;
        logic [31:0] wrData;
    } vecT;

    logic        CLK;
    logic        RST;
    logic        Start;
    logic        Reset;
    logic        Busy;
    logic [15:0] InstructionAddr;
    logic        InstructionReadReady;
    logic        InstructionReadValid;
    logic [31:0] InstructionReadData;
    logic        SDRAMReadReady;
    logic        SDRAMReadValid;
    logic [31:0] SDRAMReadData;
    logic [15:0] SDRAMReadAddr;
    logic        SDRAMWriteReady;
    logic        SDRAMWriteValid;
    logic [31:0] SDRAMWriteData;
    logic [15:0] SDRAMWriteAddr;

    int checks = 0;
    int passed = 0;
    vecT vecs [26];

    oisc_move_core dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .Start               (Start),
        .Reset               (Reset),
        .Busy                (Busy),
        .InstructionAddr     (InstructionAddr),
        .InstructionReadReady(InstructionReadReady),
        .InstructionReadValid(InstructionReadValid),
        .InstructionReadData (InstructionReadData),
        .SDRAMReadReady      (SDRAMReadReady),
        .SDRAMReadValid      (SDRAMReadValid),
        .SDRAMReadData       (SDRAMReadData),
        .SDRAMReadAddr       (SDRAMReadAddr),
        .SDRAMWriteReady     (SDRAMWriteReady),
        .SDRAMWriteValid     (SDRAMWriteValid),
        .SDRAMWriteData      (SDRAMWriteData),
        .SDRAMWriteAddr      (SDRAMWriteAddr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end else begin
            passed++;
        end
    endtask

    task automatic fetchMove(input logic [15:0] src, input logic [15:0] dst,
                             input logic [15:0] addrExp, input int waitExp);
        int waited;
        waited = 0;
        while (!InstructionReadReady && waited < 50) begin
            tick();
            waited++;
        end
        checkOutput("fetchReady", 64'(InstructionReadReady), 64'd1);
        checkOutput("fetchWait", 64'(waited), 64'(waitExp));
        checkOutput("fetchAddr", 64'(InstructionAddr), 64'(addrExp));
        InstructionReadValid = 1'b1;
        InstructionReadData  = {src, dst};
        tick();
        InstructionReadValid = 1'b0;
        InstructionReadData  = '0;
    endtask

    task automatic memRead(input logic [31:0] data, input int delay);
        int waited;
        waited = 0;
        while (!SDRAMReadReady && waited < 50) begin
            tick();
            waited++;
        end
        checkOutput("rdReady", 64'(SDRAMReadReady), 64'd1);
        checkOutput("rdAddr", 64'(SDRAMReadAddr), 64'(MAR_EXP));
        for (int d = 0; d < delay; d++) tick();
        checkOutput("rdReadyHeld", 64'(SDRAMReadReady), 64'd1);
        SDRAMReadValid = 1'b1;
        SDRAMReadData  = data;
        tick();
        SDRAMReadValid = 1'b0;
        SDRAMReadData  = '0;
    endtask

    task automatic memWrite(input logic [31:0] dataExp, input int delay, input logic [15:0] pcExp);
        int waited;
        waited = 0;
        while (!SDRAMWriteValid && waited < 50) begin
            tick();
            waited++;
        end
        checkOutput("wrValid", 64'(SDRAMWriteValid), 64'd1);
        for (int d = 0; d < delay; d++) begin
            checkOutput("wrDataHold", 64'(SDRAMWriteData), 64'(dataExp));
            checkOutput("wrAddrHold", 64'(SDRAMWriteAddr), 64'(MAR_EXP));
            checkOutput("pcHoldDuringStall", 64'(InstructionAddr), 64'(pcExp));
            tick();
        end
        checkOutput("wrData", 64'(SDRAMWriteData), 64'(dataExp));
        checkOutput("wrAddr", 64'(SDRAMWriteAddr), 64'(MAR_EXP));
        SDRAMWriteReady = 1'b1;
        tick();
        SDRAMWriteReady = 1'b0;
    endtask

    task automatic applyStimulus(input vecT v);
        fetchMove(v.src, v.dst, v.addr, v.waitCycles);
        if (v.kind == K_RD || v.kind == K_RDWR) memRead(v.rdData, v.delay);
        if (v.kind == K_WR || v.kind == K_RDWR) memWrite(v.wrData, v.delay, v.addr);
    endtask

    initial begin
        vecs[0]  = '{16'h8001, A_IMM,  16'h0000, 0, K_NONE, 32'h0, 0, 32'h0};
        vecs[1]  = '{A_IMM,    A_G1,   16'h0001, 1, K_NONE, 32'h0, 0, 32'h0};
        vecs[2]  = '{16'h0002, A_IMM,  16'h0002, 1, K_NONE, 32'h0, 0, 32'h0};
        vecs[3]  = '{A_IMM,    A_G2,   16'h0003, 1, K_NONE, 32'h0, 0, 32'h0};
        vecs[4]  = '{16'hFFFF, A_IMM,  16'h0004, 1, K_NONE, 32'h0, 0, 32'h0};
        vecs[5]  = '{A_ZERO,   A_COND, 16'h0005, 1, K_NONE, 32'h0, 0, 32'h0};
        vecs[6]  = '{A_IMM,    A_OPA,  16'h0007, 1, K_NONE, 32'h0, 0, 32'h0};
        vecs[7]  = '{A_G2,     A_ADD,  16'h0008, 1, K_NONE, 32'h0, 0, 32'h0};
        vecs[8]  = '{16'h0010, A_IMM,  16'h0009, 1, K_NONE, 32'h0, 0, 32'h0};
        vecs[9]  = '{A_IMM,    A_MAR,  16'h000A, 1, K_NONE, 32'h0, 0, 32'h0};
        vecs[10] = '{A_RES,    A_MEM,  16'h000B, 1, K_WR,   32'h0, 0, 32'h0000_0001};
        vecs[11] = '{A_G1,     A_MEM,  16'h000C, 0, K_WR,   32'h0, 3, 32'hFFFF_8001};
        vecs[12] = '{A_MEM,    A_G3,   16'h000D, 0, K_RD,   32'hA5A5_5A5A, 2, 32'h0};
        vecs[13] = '{A_G3,     A_MEM,  16'h000E, 0, K_WR,   32'h0, 1, 32'hA5A5_5A5A};
        vecs[14] = '{A_G2,     A_COND, 16'h000F, 0, K_NONE, 32'h0, 0, 32'h0};
        vecs[15] = '{A_G2,     A_SUB,  16'h0010, 1, K_NONE, 32'h0, 0, 32'h0};
        vecs[16] = '{A_RES,    A_MEM,  16'h0011, 1, K_WR,   32'h0, 0, 32'hFFFF_FFFD};
        vecs[17] = '{A_IMM,    A_G0,   16'h0012, 0, K_NONE, 32'h0, 0, 32'h0};
        vecs[18] = '{A_IMM,    A_UNM,  16'h0013, 1, K_NONE, 32'h0, 0, 32'h0};
        vecs[19] = '{A_G0,     A_MEM,  16'h0014, 1, K_WR,   32'h0, 0, 32'h0};
        vecs[20] = '{A_UNM,    A_MEM,  16'h0015, 0, K_WR,   32'h0, 0, 32'h0};
        vecs[21] = '{A_PC,     A_MEM,  16'h0016, 0, K_WR,   32'h0, 0, 32'h0000_0016};
        vecs[22] = '{16'h0020, A_IMM,  16'h0017, 0, K_NONE, 32'h0, 0, 32'h0};
        vecs[23] = '{A_IMM,    A_PC,   16'h0018, 1, K_NONE, 32'h0, 0, 32'h0};
        vecs[24] = '{A_MEM,    A_MEM,  16'h0020, 1, K_RDWR, 32'h0000_1234, 1, 32'h0000_1234};
        vecs[25] = '{A_ZERO,   A_HALT, 16'h0021, 0, K_NONE, 32'h0, 0, 32'h0};

        RST = 1'b1;
        Start = 1'b0;
        Reset = 1'b0;
        InstructionReadValid = 1'b0;
        InstructionReadData = '0;
        SDRAMReadValid = 1'b0;
        SDRAMReadData = '0;
        SDRAMWriteReady = 1'b0;
        repeat (3) tick();
        RST = 1'b0;

        checkOutput("rstBusy", 64'(Busy), 64'd0);
        checkOutput("rstPc", 64'(InstructionAddr), 64'd0);
        checkOutput("rstInstrReady", 64'(InstructionReadReady), 64'd0);
        checkOutput("rstRdReady", 64'(SDRAMReadReady), 64'd0);
        checkOutput("rstRdAddr", 64'(SDRAMReadAddr), 64'd0);
        checkOutput("rstWrValid", 64'(SDRAMWriteValid), 64'd0);
        checkOutput("rstWrData", 64'(SDRAMWriteData), 64'd0);
        checkOutput("rstWrAddr", 64'(SDRAMWriteAddr), 64'd0);
        tick();
        checkOutput("idleWithoutStart", 64'(Busy), 64'd0);

        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 26; i++) applyStimulus(vecs[i]);
        tick();
        checkOutput("haltBusy", 64'(Busy), 64'd0);
        checkOutput("haltPc", 64'(InstructionAddr), 64'h0022);

        // Reset wins over a simultaneous Start.
        Start = 1'b1;
        Reset = 1'b1;
        tick();
        Start = 1'b0;
        Reset = 1'b0;
        checkOutput("startResetBusy", 64'(Busy), 64'd0);
        checkOutput("startResetPc", 64'(InstructionAddr), 64'd0);
        tick();
        checkOutput("startResetStillIdle", 64'(Busy), 64'd0);

        // Soft reset while a read is pending; GPR3 and MAR must survive it.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        fetchMove(A_MEM, A_G3, 16'h0000, 0);
        for (int w = 0; w < 50 && !SDRAMReadReady; w++) tick();
        checkOutput("abortRdReady", 64'(SDRAMReadReady), 64'd1);
        checkOutput("abortRdAddrKept", 64'(SDRAMReadAddr), 64'(MAR_EXP));
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checkOutput("abortRdDropped", 64'(SDRAMReadReady), 64'd0);
        checkOutput("abortBusy", 64'(Busy), 64'd0);
        checkOutput("abortPc", 64'(InstructionAddr), 64'd0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        fetchMove(A_G3, A_MEM, 16'h0000, 0);
        memWrite(32'hA5A5_5A5A, 0, 16'h0000);

        // PC wrap from 0xFFFF to 0.
        fetchMove(16'hFFFF, A_IMM, 16'h0001, 0);
        fetchMove(A_IMM, A_PC, 16'h0002, 1);
        fetchMove(A_ZERO, A_ZERO, 16'hFFFF, 1);
        fetchMove(A_ZERO, A_HALT, 16'h0000, 1);
        tick();
        checkOutput("wrapHaltBusy", 64'(Busy), 64'd0);
        checkOutput("wrapHaltPc", 64'(InstructionAddr), 64'h0001);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/oisc_move_core.md
Name: oisc_move_core

Overview:
- Parametrised, second-generation move-only (OISC) core. Each instruction is one src->dst move.
- Fetches instructions over a valid/ready stream and reaches SDRAM through the existing read/write handshake ports.
- Adds over the first generation: an instruction address output, a soft-reset/start FSM, a memory address register, an add/sub transport unit, conditional skip and halt.
- Sits between the instruction ROM/stream and the SDRAM arbiter.

Parameters:
- DW, 32, GPR/data/SDRAM data width.
- MW, 16, move-address field width; instruction width = 2*MW.
- NGPR, 32, GPR count (power of 2, ≤ 2^(MW-5)).
- AW, 16, SDRAM address width.
- PCW, 16, PC width.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- Start  in  1  leave IDLE, begin fetching at PC.
- Reset  in  1  soft reset: abort, PC=0, go IDLE.
- Busy  out  1  high when not IDLE.
- InstructionAddr  out  PCW  current PC.
- InstructionReadReady  out  1  core accepts instruction.
- InstructionReadValid  in  1  instruction valid.
- InstructionReadData  in  2*MW  [2MW-1:MW]=src, [MW-1:0]=dst.
- SDRAMReadReady  out  1  read request, held until valid.
- SDRAMReadValid  in  1  read data valid.
- SDRAMReadData  in  DW  read data.
- SDRAMReadAddr  out  AW  read address.
- SDRAMWriteReady  in  1  write accepted.
- SDRAMWriteValid  out  1  write request, held until ready.
- SDRAMWriteData  out  DW  write data.
- SDRAMWriteAddr  out  AW  write address.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high. RST sets: state=IDLE, PC=0, Imm=0, MAR=0, OPA=0, RES=0, all GPRs=0, all outputs=0.
- Move map (src reads / dst writes):
  - 0x0000 ZERO: reads 0; a dst write is discarded.
  - 0x0001 PC: reads PC; a dst write jumps.
  - 0x0002 IMM: reads Imm. As dst, the src field is a literal: Imm <= sign-extend(src field to DW).
  - 0x0003 MAR: memory address register, AW LSBs.
  - 0x0004 MEM: as src, reads SDRAM[MAR]; as dst, writes SDRAM[MAR].
  - 0x0005 COND: dst; value==0 skips the next instruction.
  - 0x0007 HALT: dst, any value -> IDLE.
  - 0x0008 OPA: operand A register.
  - 0x0009 ADD: dst; RES <= OPA+value.
  - 0x000A SUB: dst; RES <= OPA-value.
  - 0x000B RES: src.
  - 0x0020+i GPR i, for i<NGPR; GPR0 reads 0 and ignores writes.
  - Unmapped: reads 0, writes discarded.
- FSM states: IDLE, FETCH, EXEC, MEMRD, MEMWR.
  - IDLE: Busy=0. Start -> FETCH.
  - FETCH: InstructionReadReady=1. On the handshake, latch src/dst -> EXEC.
  - EXEC:
    - src=MEM -> MEMRD.
    - else dst=MEM -> MEMWR, with SDRAMWriteData=value and SDRAMWriteAddr=MAR.
    - else perform the write, update PC, -> FETCH (or IDLE on HALT).
  - MEMRD: SDRAMReadReady=1, SDRAMReadAddr=MAR. On valid, the value is SDRAMReadData.
    - dst=MEM -> MEMWR.
    - else write dst, update PC, -> FETCH.
  - MEMWR: SDRAMWriteValid=1 with data/addr held stable. On ready: update PC, -> FETCH.
- PC update, on completion of a move, mod 2^PCW:
  - dst=PC: PC <= value.
  - COND with value==0: PC <= PC+2.
  - else PC <= PC+1.
  - PC wraps from 2^PCW-1 to 0.
- Latency: a non-memory move takes 2 cycles (FETCH handshake + EXEC). A memory move takes 2 cycles plus the handshake wait cycles.
- src=MEM with dst=MEM: read then write, both at the same MAR.
- ADD/SUB: the result wraps mod 2^DW; no flags. RES is visible to the next instruction.
- Priority: RST > Reset > Start.
- Reset mid-operation: abandons any pending SDRAM handshake. Valid/ready drop the next cycle. PC=0, state=IDLE. GPR, MAR and Imm are kept.
- Start outside IDLE is ignored.
- Zero-bubble fetch: FETCH is re-entered in the cycle after completion.

Decomposition:
- Shared package oisc_pkg holds:
  - move-address localparams (OISC_ZERO..OISC_RES, OISC_GPR_BASE);
  - the state enum;
  - the sign-extend function.
- One sub-module, oisc_regfile: NGPR x DW, one combinational read port, one synchronous write port, entry 0 hardwired to zero.

Test Plan:
- Basic move and sign-extension: RST, Start; IMM<-0x8001, GPR1<-IMM -> GPR1=0xFFFF8001, InstructionAddr 0->1->2, 2 cycles per move.
- Add and wrap: OPA<-0xFFFFFFFF, ADD<-GPR2 (GPR2=2) -> RES=0x00000001.
- Memory read/write with stalls:
  - MAR=0x10, MEM<-GPR1 with SDRAMWriteReady delayed 3 cycles -> write data/addr held stable, PC advances only on ready.
  - GPR3<-MEM with read valid after 2 cycles -> GPR3=read data.
- Control flow: COND<-ZERO at PC=5 -> next fetch at PC=7. PC<-IMM(0x20) -> InstructionAddr=0x20. HALT -> Busy=0.
- Reset priority: Reset asserted during MEMRD -> SDRAMReadReady=0 next cycle, PC=0, IDLE. Simultaneous Start+Reset -> stays IDLE.
- Boundary writes: PC=0xFFFF with PCW=16 -> wraps to 0. A write to GPR0 or an unmapped dst -> no state change, reads return 0.
